// File: rtl/if_fetch.sv
// IF-stage fetch unit: owns the PC, drives the instruction-memory req/ack port and presents
// fetched instructions to the IF/ID register, honouring stalls, delayed branches and flushes.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] tgt_q, tgt_d;

  logic        ack_data;
  logic        present;
  logic        consume;
  logic [31:0] next_pc;

  assign ack_data = (state_q == StReq) && imem_ack;
  assign present  = !flush && (ack_data || (state_q == StHold));
  assign consume  = present && !stall[1];
  assign next_pc  = branch_flag ? branch_target : pc_q + 32'd4;

  // Request is gated by rst so an outstanding fetch is dropped immediately.
  assign imem_req    = !rst && ((state_q == StReq) || (state_q == StDiscard));
  assign imem_addr   = pc_q;
  assign if_pc       = pc_q;
  assign if_inst     = !present ? 32'h0 : ((state_q == StHold) ? buf_q : imem_rdata);
  assign stallreq_if = !flush && !present;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    if (flush) begin
      // A request still in flight must complete before the redirect can be issued.
      if (((state_q == StReq) || (state_q == StDiscard)) && !imem_ack) begin
        tgt_d   = new_pc;
        state_d = StDiscard;
      end else begin
        pc_d    = new_pc;
        state_d = StReq;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_ack) begin
            if (consume) begin
              pc_d = next_pc;
            end else begin
              buf_d   = imem_rdata;
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (consume) begin
            pc_d    = next_pc;
            state_d = StReq;
          end
        end
        StDiscard: begin
          if (imem_ack) begin
            pc_d    = tgt_q;
            state_d = StReq;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: random-latency memory, transaction-level reference model,
// directed scenarios pinned with literal expectations, then a long randomized run.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .flush        (flush),
    .new_pc       (new_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .stallreq_if  (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a fetch is outstanding unless we just left reset or an instruction is held.
  logic        m_boot, m_held, m_drop;
  logic [31:0] m_pc, m_buf, m_tgt;
  int          wcnt;
  int          lat_lo, lat_hi;
  int          cyc_n;
  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];
  int          log_cyc[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc_n, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s1, input logic b, input logic [31:0] bt,
                     input logic f, input logic [31:0] np);
    logic mreq, got, present;
    logic [31:0] einst;
    @(negedge clk);
    rst           = r;
    stall         = 6'($urandom);
    stall[1]      = s1;
    branch_flag   = b;
    branch_target = bt;
    flush         = f;
    new_pc        = np;
    mreq          = !r && !m_boot && !m_held;
    imem_ack      = 1'b0;
    imem_rdata    = $urandom;
    if (mreq) begin
      if (wcnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(m_pc);
      end else begin
        wcnt--;
      end
    end
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, mreq});
    if (r) begin
      m_boot = 1'b1;
      m_held = 1'b0;
      m_drop = 1'b0;
      m_pc   = 32'h0;
    end else begin
      got     = mreq && imem_ack && !m_drop;
      present = !f && (m_held || got);
      einst   = present ? (m_held ? m_buf : imem_rdata) : 32'h0;
      if (mreq) chk("imem_addr", imem_addr, m_pc);
      chk("if_inst", if_inst, einst);
      chk("stallreq_if", {31'h0, stallreq_if}, {31'h0, !f && !present});
      if (present) begin
        chk("if_pc", if_pc, m_pc);
        log_pc.push_back(m_pc);
        log_inst.push_back(einst);
        log_cyc.push_back(cyc_n);
      end
      if (f) begin
        if (mreq && !imem_ack) begin
          m_drop = 1'b1;
          m_tgt  = np;
        end else begin
          m_pc   = np;
          m_boot = 1'b0;
          m_held = 1'b0;
          m_drop = 1'b0;
        end
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_drop) begin
        if (imem_ack) begin
          m_pc   = m_tgt;
          m_drop = 1'b0;
        end
      end else if (present) begin
        if (s1) begin
          if (!m_held) begin
            m_held = 1'b1;
            m_buf  = imem_rdata;
          end
        end else begin
          m_pc   = b ? bt : m_pc + 32'd4;
          m_held = 1'b0;
        end
      end
    end
    if (imem_ack || r) wcnt = $urandom_range(lat_hi, lat_lo);
    cyc_n++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    log_pc.delete();
    log_inst.delete();
    log_cyc.delete();
    cyc_n = 0;
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_lo = lo;
    lat_hi = hi;
  endtask

  initial begin
    rst = 1'b1; stall = '0; branch_flag = 1'b0; branch_target = '0;
    flush = 1'b0; new_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
    m_boot = 1'b1; m_held = 1'b0; m_drop = 1'b0; m_pc = '0; m_buf = '0; m_tgt = '0;
    wcnt = 0; cyc_n = 0;

    // Zero-wait streaming: one instruction per cycle after the idle cycle.
    set_lat(0, 0);
    do_reset(2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t1_count", 32'(log_pc.size()), 32'd4);
    chk("t1_pc0", log_pc[0], 32'h0);
    chk("t1_pc1", log_pc[1], 32'h4);
    chk("t1_pc2", log_pc[2], 32'h8);
    chk("t1_pc3", log_pc[3], 32'hC);
    chk("t1_cyc0", 32'(log_cyc[0]), 32'd1);

    // Three wait states: first instruction lands on cycle 4.
    set_lat(3, 3);
    do_reset(1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t2_cyc0", 32'(log_cyc[0]), 32'd4);
    chk("t2_inst0", log_inst[0], mem(32'h0));

    // Stall for two cycles on the ack of address 8, then release.
    set_lat(0, 0);
    do_reset(1);
    for (int i = 0; i < 7; i++) cyc(1'b0, (i == 3 || i == 4), 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t3_hold_pc", log_pc[4], 32'h8);
    chk("t3_hold_inst", log_inst[4], mem(32'h8));
    chk("t3_after_pc", log_pc[5], 32'hC);
    chk("t3_after_cyc", 32'(log_cyc[5]), 32'd6);

    // Branch while 0x14 is presented; a branch during the idle cycle is ignored.
    do_reset(1);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, 1'b0, (i == 0 || i == 6), (i == 0) ? 32'h300 : 32'h100, 1'b0, 32'h0);
    chk("t4_slot", log_pc[5], 32'h14);
    chk("t4_target", log_pc[6], 32'h100);
    chk("t4_first", log_pc[0], 32'h0);

    // Flush two cycles before a late ack: ack data dropped, refetch at 0x180.
    set_lat(4, 4);
    do_reset(1);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, (i == 3), 32'h180);
    chk("t5_pc", log_pc[0], 32'h180);
    chk("t5_cyc", 32'(log_cyc[0]), 32'd10);
    chk("t5_inst", log_inst[0], mem(32'h180));

    // Reset while waiting on ack: fetch restarts at address 0.
    do_reset(1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    do_reset(1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("t6_pc", log_pc[0], 32'h0);
    chk("t6_cyc", 32'(log_cyc[0]), 32'd5);

    // Randomized traffic against the model.
    set_lat(0, 3);
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(99) == 0), ($urandom_range(9) < 3), ($urandom_range(4) == 0),
          $urandom, ($urandom_range(19) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
